vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Timing generator and pixel sink for the 640x480@60 Hz VGA output path, clocked at 25 MHz pixel rate. It produces the horizontal/vertical scan counters, HSYNC/VSYNC, and the pixel coordinates (`pix_x`/`pix_y`) that drive the pattern/frame-source block. It consumes the 16-bit RGB565 `pix_data` returned by that block one clock later. Valid pixels are gated onto the `rgb` output in exact alignment with the active-video window.

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, active lines per frame
- V_FRONT, 10, vertical front porch
- H_TOTAL, H_SYNC+H_BACK+H_VALID+H_FRONT (800), derived
- V_TOTAL, V_SYNC+V_BACK+V_VALID+V_FRONT (525), derived

Ports:
- vga_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  asynchronous, active-low reset
- pix_data  in  16  RGB565 pixel returned by the source, one clock after `pix_x`/`pix_y`
- pix_x  out  12  requested pixel X coordinate, 12'hFFF when no request
- pix_y  out  12  requested pixel Y coordinate, 12'hFFF when no request
- pix_data_req  out  1  coordinate request strobe, one clock ahead of active video
- rgb_valid  out  1  active-video window
- rgb  out  16  RGB565 to DAC; 16'h0000 outside active video
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_start  out  1  one-clock pulse at scan position (0,0)

## Operation
- `cnt_h` and `cnt_v` are 12-bit registers, the only state in the block; all outputs decode them combinationally.
- `cnt_h` counts 0..H_TOTAL-1 every clock and wraps to 0.
- `cnt_v` increments only when `cnt_h == H_TOTAL-1`. It wraps 0 after V_TOTAL-1, at the same edge `cnt_h` wraps.
- Horizontal active window: HA = [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID), i.e. [144,784).
- Vertical active window: VA = [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), i.e. [35,515).
- `hsync` = 0 while `cnt_h < H_SYNC`, else 1.
- `vsync` = 0 while `cnt_v < V_SYNC`, else 1.
- `rgb_valid` = `cnt_h` in HA and `cnt_v` in VA.
- `pix_data_req` = `cnt_h` in [143,783) and `cnt_v` in VA. It is HA shifted one clock early to cover the source's one-clock registered latency.
- When `pix_data_req` = 1:
  - `pix_x` = `cnt_h` - 143, range 0..639.
  - `pix_y` = `cnt_v` - 35, range 0..479.
- When `pix_data_req` = 0, `pix_x` = `pix_y` = 12'hFFF. The source returns black for out-of-range coordinates; `rgb` does not depend on this.
- `rgb` = `rgb_valid` ? `pix_data` : 16'h0000.
- `frame_start` = (`cnt_h` == 0) && (`cnt_v` == 0).
- Subtraction width: 12-bit unsigned. The result is only used inside the request window, so it never underflows there.

## Timing
- Reset values (asynchronous): `cnt_h` = `cnt_v` = 0.
- Resulting outputs during reset:
  - `hsync` = 0, `vsync` = 0, `frame_start` = 1.
  - `rgb_valid` = 0, `pix_data_req` = 0.
  - `pix_x` = `pix_y` = 12'hFFF, `rgb` = 0.
- First clock after reset release: `cnt_h` = 1, so `frame_start` drops.
- Latency: coordinate (x,y) is issued at clock t; `pix_data` for (x,y) is sampled at t+1 and driven on `rgb` in that same cycle t+1.
- Request boundaries:
  - First request of a line: `cnt_h` = 143, `pix_x` = 0. Last request: `cnt_h` = 782, `pix_x` = 639.
  - `cnt_h` = 783: `pix_data_req` = 0 while `rgb_valid` = 1 (last pixel displayed).
- Line period 800 clocks; frame period 420000 clocks.
- Simultaneous wrap: at `cnt_h` = 799 and `cnt_v` = 524, both counters go to 0 on the next edge.
- Reset mid-frame: counters return to 0 immediately. Display resumes from the top-left of a new frame with no partial-frame state retained.

## Test plan
- Reset held, then released:
  - During reset: `hsync` = 0, `vsync` = 0, `rgb` = 0, `pix_x` = 12'hFFF, `frame_start` = 1.
  - After release: `frame_start` = 0 from the first clock; next `frame_start` pulse exactly 420000 clocks later.
- Free run, one line: `hsync` low for exactly 96 clocks and high for 704; `rgb_valid` high for exactly 640 clocks per active line.
- Free run, one frame: `vsync` low for exactly 2 lines (1600 clocks); `rgb_valid` is asserted on 480 lines, `cnt_v` 35..514.
- Source model returning {4'h0, `pix_x`} registered by one clock:
  - At the first active clock (`cnt_h` = 144, `cnt_v` = 35), `rgb` = 16'h0000.
  - At the last active clock of the line, `rgb` = 16'h027F (639).
  - At `cnt_h` = 784, `rgb` = 0.
- `pix_y` check: at `cnt_v` = 514, `cnt_h` = 143 → `pix_y` = 479, `pix_x` = 0. At `cnt_v` = 515 → `pix_data_req` = 0 and `pix_y` = 12'hFFF for the whole line.
- Reset asserted at `cnt_h` = 400, `cnt_v` = 200:
  - Immediately: `rgb` = 0, `rgb_valid` = 0.
  - After release: first active pixel appears 144 + 35*800 = 28144 clocks later.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing generator and pixel sink: free-running line/frame counters
// decoded into syncs, source coordinate requests and the gated RGB565 output.
module vga_timing_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_data_req,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC);
  localparam logic [11:0] HA_START  = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END    = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] VA_START  = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_END    = 12'(V_SYNC + V_BACK + V_VALID);
  localparam logic [11:0] REQ_START = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] REQ_END   = 12'(H_SYNC + H_BACK + H_VALID - 1);

  logic [11:0] cnt_h_q, cnt_h_d;
  logic [11:0] cnt_v_q, cnt_v_d;
  logic        h_active, v_active, h_request;

  // The vertical counter advances on the last clock of each line, so both wrap together.
  always_comb begin
    cnt_h_d = cnt_h_q + 12'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = 12'd0;
      cnt_v_d = (cnt_v_q == V_LAST) ? 12'd0 : cnt_v_q + 12'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= 12'd0;
      cnt_v_q <= 12'd0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  assign h_active  = (cnt_h_q >= HA_START) && (cnt_h_q < HA_END);
  assign v_active  = (cnt_v_q >= VA_START) && (cnt_v_q < VA_END);
  // Requests lead the display window by one clock to absorb the source's register stage.
  assign h_request = (cnt_h_q >= REQ_START) && (cnt_h_q < REQ_END);

  always_comb begin
    pix_data_req = h_request && v_active;
    rgb_valid    = h_active && v_active;
    pix_x        = 12'hFFF;
    pix_y        = 12'hFFF;
    if (pix_data_req) begin
      pix_x = cnt_h_q - REQ_START;
      pix_y = cnt_v_q - VA_START;
    end
    rgb         = rgb_valid ? pix_data : 16'h0000;
    hsync       = (cnt_h_q >= H_SYNC_W);
    vsync       = (cnt_v_q >= V_SYNC_W);
    frame_start = (cnt_h_q == 12'd0) && (cnt_v_q == 12'd0);
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full 640x480 instance for line-level boundaries and a
// shrunken-timing instance for frame-level behaviour, both tracked by a flat position model.
module tb_vga_timing_ctrl;

  localparam int F_HS = 96, F_HB = 48, F_HV = 640, F_HF = 16;
  localparam int F_VS = 2,  F_VB = 33, F_VV = 480, F_VF = 10;
  localparam int F_FRAME = (F_HS + F_HB + F_HV + F_HF) * (F_VS + F_VB + F_VV + F_VF);
  localparam int S_HS = 4, S_HB = 3, S_HV = 10, S_HF = 2;
  localparam int S_VS = 2, S_VB = 3, S_VV = 5,  S_VF = 2;
  localparam int S_FRAME = (S_HS + S_HB + S_HV + S_HF) * (S_VS + S_VB + S_VV + S_VF);

  logic        clk = 1'b0;
  logic        rstFullN = 1'b0;
  logic        rstSmallN = 1'b0;
  logic [15:0] srcFullQ, srcSmallQ;
  logic [11:0] pxF, pyF, pxS, pyS;
  logic        reqF, validF, hsF, vsF, fsF;
  logic        reqS, validS, hsS, vsS, fsS;
  logic [15:0] rgbF, rgbS;
  int          posFull = 0;
  int          posSmall = 0;
  int          total = 0;
  int          bad = 0;
  int          fStep = 0;
  int          sStep = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl dutFull (
    .vga_clk(clk), .sys_rst_n(rstFullN), .pix_data(srcFullQ),
    .pix_x(pxF), .pix_y(pyF), .pix_data_req(reqF), .rgb_valid(validF),
    .rgb(rgbF), .hsync(hsF), .vsync(vsF), .frame_start(fsF)
  );

  vga_timing_ctrl #(
    .H_SYNC(S_HS), .H_BACK(S_HB), .H_VALID(S_HV), .H_FRONT(S_HF),
    .V_SYNC(S_VS), .V_BACK(S_VB), .V_VALID(S_VV), .V_FRONT(S_VF)
  ) dutSmall (
    .vga_clk(clk), .sys_rst_n(rstSmallN), .pix_data(srcSmallQ),
    .pix_x(pxS), .pix_y(pyS), .pix_data_req(reqS), .rgb_valid(validS),
    .rgb(rgbS), .hsync(hsS), .vsync(vsS), .frame_start(fsS)
  );

  // Pattern source: returns {4'h0, x} for the requested coordinate one clock later.
  always @(posedge clk) begin
    srcFullQ  <= {4'h0, pxF};
    srcSmallQ <= {4'h0, pxS};
  end

  always @(posedge clk or negedge rstFullN) begin
    if (!rstFullN) posFull <= 0;
    else           posFull <= (posFull + 1) % F_FRAME;
  end

  always @(posedge clk or negedge rstSmallN) begin
    if (!rstSmallN) posSmall <= 0;
    else            posSmall <= (posSmall + 1) % S_FRAME;
  end

  // Expected outputs from a flat scan position: {pix_x, pix_y, req, valid, rgb, hsync, vsync, frame_start}.
  function automatic logic [44:0] expectOut(int pos, int hs, int hb, int hv, int hf,
                                            int vs, int vb, int vv);
    int ht, h, v, x0, y0;
    logic hAct, vAct, hNextAct, req;
    logic [11:0] ex, ey;
    logic [15:0] er;
    ht = hs + hb + hv + hf;
    h  = pos % ht;
    v  = pos / ht;
    x0 = hs + hb;
    y0 = vs + vb;
    hAct     = (h >= x0) && (h < x0 + hv);
    hNextAct = (h + 1 >= x0) && (h + 1 < x0 + hv);
    vAct     = (v >= y0) && (v < y0 + vv);
    req = hNextAct && vAct;
    ex  = req ? 12'(h + 1 - x0) : 12'hFFF;
    ey  = req ? 12'(v - y0) : 12'hFFF;
    er  = (hAct && vAct) ? 16'(h - x0) : 16'h0000;
    return {ex, ey, req, hAct && vAct, er, h >= hs, v >= vs, pos == 0};
  endfunction

  task automatic finishSim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic checkOutput(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cmpCycle(string name, int pos, logic [44:0] act, logic [44:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s pos=%0d actual=%h required=%h", name, pos, act, exp);
      if (bad >= 40) finishSim();
    end
  endtask

  always @(negedge clk) begin
    cmpCycle("fullCycle", posFull,
             {pxF, pyF, reqF, validF, rgbF, hsF, vsF, fsF},
             expectOut(posFull, F_HS, F_HB, F_HV, F_HF, F_VS, F_VB, F_VV));
    cmpCycle("smallCycle", posSmall,
             {pxS, pyS, reqS, validS, rgbS, hsS, vsS, fsS},
             expectOut(posSmall, S_HS, S_HB, S_HV, S_HF, S_VS, S_VB, S_VV));
  end

  task automatic nextFull();
    @(negedge clk);
    fStep++;
  endtask

  task automatic nextSmall();
    @(negedge clk);
    sStep++;
  endtask

  // Full-size instance: reset values, one complete line, and the first active line's edges.
  task automatic applyStimulusFull();
    int hsLow, hsHigh, validCnt;
    repeat (3) @(negedge clk);
    checkOutput("rstHsync", 16'(hsF), 16'd0);
    checkOutput("rstVsync", 16'(vsF), 16'd0);
    checkOutput("rstRgb", rgbF, 16'h0000);
    checkOutput("rstPixX", 16'(pxF), 16'h0FFF);
    checkOutput("rstFrameStart", 16'(fsF), 16'd1);
    #2 rstFullN = 1'b1;
    fStep = 0;
    hsLow = 0;
    hsHigh = 0;
    while (fStep < 800) begin
      nextFull();
      if (fStep == 1) checkOutput("relFrameStart", 16'(fsF), 16'd0);
      if (hsF) hsHigh++;
      else     hsLow++;
    end
    checkOutput("hsyncLowCnt", 16'(hsLow), 16'd96);
    checkOutput("hsyncHighCnt", 16'(hsHigh), 16'd704);
    while (fStep < 28000) nextFull();
    validCnt = 0;
    while (fStep < 28800) begin
      nextFull();
      if (validF) validCnt++;
      case (fStep)
        28143: begin
          checkOutput("firstReq", 16'(reqF), 16'd1);
          checkOutput("firstReqX", 16'(pxF), 16'd0);
          checkOutput("firstReqY", 16'(pyF), 16'd0);
          checkOutput("firstReqValid", 16'(validF), 16'd0);
        end
        28144: begin
          checkOutput("firstValid", 16'(validF), 16'd1);
          checkOutput("firstRgb", rgbF, 16'h0000);
        end
        28782: begin
          checkOutput("lastReq", 16'(reqF), 16'd1);
          checkOutput("lastReqX", 16'(pxF), 16'h027F);
        end
        28783: begin
          checkOutput("lastPixReq", 16'(reqF), 16'd0);
          checkOutput("lastPixValid", 16'(validF), 16'd1);
          checkOutput("lastRgb", rgbF, 16'h027F);
          checkOutput("lastPixX", 16'(pxF), 16'h0FFF);
        end
        28784: begin
          checkOutput("afterRgb", rgbF, 16'h0000);
          checkOutput("afterValid", 16'(validF), 16'd0);
        end
        default: ;
      endcase
    end
    checkOutput("validPerLine", 16'(validCnt), 16'd640);
  endtask

  // Shrunken instance (19x12 scan): frame period, vsync width, last lines, mid-frame reset.
  task automatic applyStimulusSmall();
    int vsLow, validCnt, validRise, fsAt, badLine, waited;
    logic prevValid;
    #2 rstSmallN = 1'b1;
    sStep = 0;
    vsLow = 0;
    validCnt = 0;
    validRise = 0;
    fsAt = -1;
    badLine = 0;
    prevValid = 1'b0;
    while (sStep < S_FRAME) begin
      nextSmall();
      if (!vsS) vsLow++;
      if (validS) validCnt++;
      if (validS && !prevValid) validRise++;
      prevValid = validS;
      if (fsS && fsAt < 0) fsAt = sStep;
      if (sStep == 9 * 19 + 6) begin
        checkOutput("lastLinePixY", 16'(pyS), 16'd4);
        checkOutput("lastLinePixX", 16'(pxS), 16'd0);
      end
      if (sStep >= 10 * 19 && sStep < 11 * 19 && (reqS || pyS != 12'hFFF)) badLine++;
    end
    checkOutput("framePeriod", 16'(fsAt), 16'(S_FRAME));
    checkOutput("vsyncLowCnt", 16'(vsLow), 16'd38);
    checkOutput("validCycles", 16'(validCnt), 16'd50);
    checkOutput("validLines", 16'(validRise), 16'd5);
    checkOutput("postActiveLine", 16'(badLine), 16'd0);
    while (sStep < S_FRAME + 6 * 19 + 10) nextSmall();
    checkOutput("preRstValid", 16'(validS), 16'd1);
    #2 rstSmallN = 1'b0;
    #1;
    checkOutput("midRstRgb", rgbS, 16'h0000);
    checkOutput("midRstValid", 16'(validS), 16'd0);
    repeat (3) @(negedge clk);
    #2 rstSmallN = 1'b1;
    waited = 0;
    while (!validS && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("resumeLatency", 16'(waited), 16'd102);
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("[TB] FAIL watchdog actual=timeout required=completion");
    finishSim();
  end

  initial begin
    $display("[TB] starting vga_timing_ctrl bench");
    applyStimulusFull();
    applyStimulusSmall();
    repeat (5) @(negedge clk);
    finishSim();
  end

endmodule
